multi_edge_pulser: RTL and testbench

- Parametrised, multi-channel successor to the single-channel synchroniser/rising-edge pulser.
- Each channel:
  - synchronises one asynchronous input through a configurable-depth flop chain;
  - detects rise, fall or both edges, selected per channel at run time;
  - emits a stretched pulse of fixed length;
  - enforces a hold-off window and flags edges lost inside that window.
- Sits at the front end of the trigger/DAQ logic, where asynchronous discriminator or control lines enter the clock domain.

---
 rtl/edge_pkg.sv | 11 +
 rtl/edge_pulser_ch.sv | 88 ++++++++
 rtl/multi_edge_pulser.sv | 70 +++++++
 tb/tb_multi_edge_pulser.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge pulser: per-channel edge-select encodings.
package edge_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_t;

endpackage

// File: rtl/edge_pulser_ch.sv
// One channel: input synchroniser, edge detector, non-retriggerable pulse/hold-off
// counter and sticky missed-edge flag.
module edge_pulser_ch
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int HOLDOFF     = 0,
    parameter int BUSY_W      = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       signal_i,
    input  edge_mode_t mode_i,
    input  logic       missed_clr_i,
    input  logic       primed_i,
    output logic       pulse_o,
    output logic       pulse_next_o,
    output logic       level_o,
    output logic       missed_o
);

    localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(PULSE_LEN + HOLDOFF);
    localparam logic [BUSY_W-1:0] HOLD_LVL  = BUSY_W'(HOLDOFF);
    localparam logic [BUSY_W-1:0] BUSY_ONE  = BUSY_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [BUSY_W-1:0]      busy_q, busy_d;
    logic                   pulse_q, pulse_d;
    logic                   missed_q, missed_d;

    logic sync_last, rise, fall, det, accept, reject;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign rise      = sync_last & ~hist_q;
    assign fall      = ~sync_last & hist_q;

    always_comb begin
        det = 1'b0;
        case (mode_i)
            MODE_RISE: det = rise;
            MODE_FALL: det = fall;
            MODE_BOTH: det = rise | fall;
            default:   det = 1'b0;
        endcase
    end

    // A counter at 1 expires this edge, so a new edge may be accepted now;
    // this gives back-to-back acceptance at a spacing of PULSE_LEN+HOLDOFF.
    assign accept = det & primed_i & (busy_q <= BUSY_ONE);
    assign reject = det & primed_i & ~accept;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], signal_i};
        hist_d = sync_last;
        busy_d = busy_q;
        if (accept) begin
            busy_d = BUSY_LOAD;
        end else if (busy_q != '0) begin
            busy_d = busy_q - BUSY_ONE;
        end
        pulse_d  = (busy_d > HOLD_LVL);
        missed_d = (missed_q & ~missed_clr_i) | reject;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q   <= '0;
            hist_q   <= 1'b0;
            busy_q   <= '0;
            pulse_q  <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            hist_q   <= hist_d;
            busy_q   <= busy_d;
            pulse_q  <= pulse_d;
            missed_q <= missed_d;
        end
    end

    assign pulse_o      = pulse_q;
    assign pulse_next_o = pulse_d;
    assign level_o      = sync_last;
    assign missed_o     = missed_q;

endmodule

// File: rtl/multi_edge_pulser.sv
// Multi-channel asynchronous-input edge pulser: NCH independent channels sharing a
// post-reset priming counter, plus a registered OR of all pulses.
module multi_edge_pulser
    import edge_pkg::*;
#(
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int HOLDOFF     = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NCH-1:0]   signal,
    input  logic [2*NCH-1:0] mode,
    input  logic [NCH-1:0]   missed_clr,
    output logic [NCH-1:0]   pulse,
    output logic [NCH-1:0]   level,
    output logic [NCH-1:0]   missed,
    output logic             any_pulse
);

    localparam int CW = $clog2(PULSE_LEN + HOLDOFF + 1);
    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRIME_END = PW'(SYNC_STAGES + 1);

    logic [PW-1:0]  prime_q, prime_d;
    logic           primed;
    logic           any_pulse_q, any_pulse_d;
    logic [NCH-1:0] pulse_next;

    assign primed = (prime_q == PRIME_END);

    always_comb begin
        prime_d     = primed ? prime_q : prime_q + PW'(1);
        any_pulse_d = |pulse_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prime_q     <= '0;
            any_pulse_q <= 1'b0;
        end else begin
            prime_q     <= prime_d;
            any_pulse_q <= any_pulse_d;
        end
    end

    assign any_pulse = any_pulse_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        edge_pulser_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .PULSE_LEN   (PULSE_LEN),
            .HOLDOFF     (HOLDOFF),
            .BUSY_W      (CW)
        ) u_ch (
            .clock        (clock),
            .reset        (reset),
            .signal_i     (signal[i]),
            .mode_i       (edge_mode_t'(mode[2*i +: 2])),
            .missed_clr_i (missed_clr[i]),
            .primed_i     (primed),
            .pulse_o      (pulse[i]),
            .pulse_next_o (pulse_next[i]),
            .level_o      (level[i]),
            .missed_o     (missed[i])
        );
    end

endmodule

// File: tb/tb_multi_edge_pulser.sv
// Scoreboard bench for multi_edge_pulser: a time-indexed reference model predicts the
// outputs after every clock edge; a separate monitor compares them against the DUT.
module tb_multi_edge_pulser;

    localparam int NCH  = 4;
    localparam int SS   = 3;
    localparam int PL   = 2;
    localparam int HO   = 3;
    localparam int MAXN = 4096;
    localparam int NONE = -100000;

    logic             clock = 1'b0;
    logic             reset;
    logic [NCH-1:0]   signal;
    logic [2*NCH-1:0] mode;
    logic [NCH-1:0]   missed_clr;
    logic [NCH-1:0]   pulse, level, missed;
    logic             any_pulse;

    multi_edge_pulser #(
        .NCH         (NCH),
        .SYNC_STAGES (SS),
        .PULSE_LEN   (PL),
        .HOLDOFF     (HO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .signal     (signal),
        .mode       (mode),
        .missed_clr (missed_clr),
        .pulse      (pulse),
        .level      (level),
        .missed     (missed),
        .any_pulse  (any_pulse)
    );

    always #5 clock = ~clock;

    typedef struct {
        int             n;
        logic [NCH-1:0] pulse;
        logic [NCH-1:0] level;
        logic [NCH-1:0] missed;
        logic           any;
    } exp_t;

    exp_t q[$];

    // stimulus history indexed by edge number: the value presented at edge n
    logic [NCH-1:0]   s_hist [MAXN];
    logic             r_hist [MAXN];
    logic [2*NCH-1:0] m_hist [MAXN];
    logic [NCH-1:0]   c_hist [MAXN];

    int   last_acc [NCH];
    logic mis_m    [NCH];
    int   last_rst;
    int   n_edge;
    int   checks;
    int   fails;
    bit   done;

    // synchroniser stage k after edge n holds the input seen k edges earlier,
    // unless a reset occurred anywhere in that window
    function automatic logic stage(int ch, int k, int n);
        if (n - k < 0) return 1'b0;
        for (int m = n - k; m <= n; m++) begin
            if (r_hist[m]) return 1'b0;
        end
        return s_hist[n-k][ch];
    endfunction

    function automatic void model_edge(int n);
        exp_t e;
        logic [1:0] md;
        logic l, h, det, rej;
        e.n = n;
        e.pulse = '0;
        e.level = '0;
        e.missed = '0;
        if (r_hist[n]) last_rst = n;
        for (int ch = 0; ch < NCH; ch++) begin
            if (r_hist[n]) begin
                last_acc[ch] = NONE;
                mis_m[ch] = 1'b0;
            end else begin
                l = stage(ch, SS - 1, n - 1);
                h = stage(ch, SS, n - 1);
                md = m_hist[n][2*ch +: 2];
                det = (md[0] & l & ~h) | (md[1] & ~l & h);
                rej = 1'b0;
                if (det && (n - last_rst >= SS + 2)) begin
                    if (n - last_acc[ch] >= PL + HO) last_acc[ch] = n;
                    else rej = 1'b1;
                end
                mis_m[ch] = (mis_m[ch] & ~c_hist[n][ch]) | rej;
                e.pulse[ch] = (last_acc[ch] != NONE) && (n - last_acc[ch] < PL);
                e.level[ch] = stage(ch, SS - 1, n);
            end
            e.missed[ch] = mis_m[ch];
        end
        e.any = |e.pulse;
        q.push_back(e);
    endfunction

    // drive one edge's worth of inputs, record them, predict, advance
    task automatic step(input logic rst, input logic [NCH-1:0] sig,
                        input logic [2*NCH-1:0] md, input logic [NCH-1:0] clr);
        reset = rst;
        signal = sig;
        mode = md;
        missed_clr = clr;
        s_hist[n_edge] = sig;
        r_hist[n_edge] = rst;
        m_hist[n_edge] = md;
        c_hist[n_edge] = clr;
        model_edge(n_edge);
        n_edge++;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic cmp(input string name, input int n, input logic [NCH-1:0] act,
                       input logic [NCH-1:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s edge %0d: got %b expected %b", name, n, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("pulse", e.n, pulse, e.pulse);
                cmp("level", e.n, level, e.level);
                cmp("missed", e.n, missed, e.missed);
                cmp("any_pulse", e.n, {{(NCH-1){1'b0}}, any_pulse}, {{(NCH-1){1'b0}}, e.any});
            end
        end
    end

    initial begin : driver
        logic [NCH-1:0]   sig;
        logic [2*NCH-1:0] md;
        logic [NCH-1:0]   clr;
        logic             rst;
        int unsigned      shift;

        checks = 0;
        fails = 0;
        done = 1'b0;
        n_edge = 0;
        last_rst = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            last_acc[ch] = NONE;
            mis_m[ch] = 1'b0;
        end

        // input high through reset, rise mode everywhere: must not pulse after release
        md = {NCH{2'b01}};
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0001, md, '0);
        for (int i = 0; i < 12; i++) step(1'b0, 4'b0001, md, '0);

        // hold-off on channel 1: rises at +0, +4, +8; clear coincides with a rejected edge
        sig = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            sig[1] = (i % 4 < 2);
            clr = (i == 4 + SS) ? 4'b0010 : 4'b0000;
            step(1'b0, sig, md, clr);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0001, md, (i == 8) ? 4'b0010 : 4'b0000);

        // both-edge mode on channel 3 with a long hold
        md[7:6] = 2'b11;
        for (int i = 0; i < 22; i++) step(1'b0, {(i < 20), 3'b001}, md, '0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0001, md, '0);

        // mode switched off mid-pulse on channel 2, then further edges ignored
        step(1'b0, 4'b0101, md, '0);
        for (int i = 0; i < SS + 1; i++) step(1'b0, 4'b0101, md, '0);
        md[5:4] = 2'b00;
        for (int i = 0; i < 6; i++) step(1'b0, (i % 2) ? 4'b0101 : 4'b0001, md, '0);
        for (int i = 0; i < 6; i++) step(1'b0, 4'b0001, md, '0);

        // reset mid-pulse, then edges arriving straight after release
        md = {NCH{2'b11}};
        for (int i = 0; i < SS + 1; i++) step(1'b0, 4'b1111, md, '0);
        step(1'b1, 4'b1111, md, '0);
        for (int i = 0; i < 3; i++) step(1'b0, (i % 2) ? 4'b1111 : 4'b0000, md, '0);
        for (int i = 0; i < 10; i++) step(1'b0, 4'b1010, md, '0);

        // randomized traffic with varying edge density
        sig = 4'b1010;
        for (int blk = 0; blk < 15; blk++) begin
            shift = $urandom_range(0, 4);
            for (int i = 0; i < 200; i++) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    if (($urandom & ((32'd1 << shift) - 1)) == 0) sig[ch] = ~sig[ch];
                    if ($urandom_range(0, 49) == 0) md[2*ch +: 2] = 2'($urandom_range(0, 3));
                end
                clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
                rst = ($urandom_range(0, 399) == 0);
                step(rst, sig, md, clr);
            end
        end

        done = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
